// File: rtl/lif_pkg.sv
// lif_pkg
//   Shared declarations for the time-multiplexed LIF scheduler:
//   - state_t      : scheduler FSM states (idle / sweeping)
//   - DEF_*        : default width and behaviour constants
//   - sat_add_u    : unsigned add clamped to an arbitrary bit width (<= 32)
package lif_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_N_NEURONS  = 8;
    localparam int DEF_V_WIDTH    = 16;
    localparam int DEF_I_WIDTH    = 8;
    localparam int DEF_LEAK_SHIFT = 4;
    localparam int DEF_V_RESET    = 0;

    // Unsigned a + b, clamped to 2^width - 1. The sum is formed in 33 bits
    // so the carry out of a 32-bit operand is never lost.
    function automatic logic [31:0] sat_add_u(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// lif_update_unit
//   Combinational leaky-integrate-and-fire step for one neuron.
//   Ports:
//     v_in   : current membrane potential
//     i_in   : input current
//     thr    : firing threshold
//     v_out  : next membrane potential (V_RESET after a spike)
//     spike  : 1 when the leaked, integrated, saturated value reaches thr
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int I_WIDTH    = DEF_I_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int V_RESET    = DEF_V_RESET
) (
    input  logic [V_WIDTH-1:0] v_in,
    input  logic [I_WIDTH-1:0] i_in,
    input  logic [V_WIDTH-1:0] thr,
    output logic [V_WIDTH-1:0] v_out,
    output logic               spike
);

    logic [V_WIDTH-1:0] w_leaked;
    logic [V_WIDTH-1:0] w_sat;

    // v - (v >> k) can never go below zero, so only the add needs clamping.
    assign w_leaked = v_in - (v_in >> LEAK_SHIFT);
    assign w_sat    = V_WIDTH'(sat_add_u(32'(w_leaked), 32'(i_in), V_WIDTH));
    assign spike    = (w_sat >= thr);
    assign v_out    = spike ? V_WIDTH'(V_RESET) : w_sat;

endmodule

// File: rtl/lif_ts_scheduler.sv
// lif_ts_scheduler
//   Shares one lif_update_unit across N_NEURONS virtual neurons. A tick
//   starts a sweep that updates neuron idx on each clock in index order;
//   the final spike vector is published with a one-cycle done pulse.
//   Ports:
//     clk, rst_n   : clock (rising edge), synchronous active-low reset
//     tick         : start a timestep sweep (ignored and flagged if busy)
//     threshold    : firing threshold, captured when a tick is accepted
//     cfg_we/addr/data : write input current of one neuron (any state)
//     dbg_sel      : neuron whose membrane is shown on dbg_vmem
//     busy         : sweep in progress
//     done         : one-cycle pulse after the last neuron is updated
//     spike_vec    : spike bits of the last completed sweep
//     dbg_vmem     : registered membrane potential of neuron dbg_sel
//     overrun      : sticky, a tick arrived while a sweep was running
module lif_ts_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int I_WIDTH    = DEF_I_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int V_RESET    = DEF_V_RESET,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [I_WIDTH-1:0]   cfg_data,
    input  logic [IDX_W-1:0]     dbg_sel,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic [V_WIDTH-1:0]   dbg_vmem,
    output logic                 overrun
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [V_WIDTH-1:0]   r_v [N_NEURONS];
    logic [I_WIDTH-1:0]   r_i [N_NEURONS];
    logic [N_NEURONS-1:0] r_spk_acc;
    logic [N_NEURONS-1:0] r_spike_vec;
    logic [V_WIDTH-1:0]   r_thr_q;
    logic [V_WIDTH-1:0]   r_dbg_vmem;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;

    logic                 w_start;
    logic                 w_last;
    logic [V_WIDTH-1:0]   w_v_out;
    logic                 w_spike;
    logic [N_NEURONS-1:0] w_acc_nxt;

    lif_update_unit #(
        .V_WIDTH    (V_WIDTH),
        .I_WIDTH    (I_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .V_RESET    (V_RESET)
    ) u_update (
        .v_in  (r_v[r_idx]),
        .i_in  (r_i[r_idx]),
        .thr   (r_thr_q),
        .v_out (w_v_out),
        .spike (w_spike)
    );

    assign w_last = (r_state == ST_RUN) && (r_idx == IDX_W'(N_NEURONS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_acc_nxt   = r_spk_acc;
        case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                w_acc_nxt[r_idx] = w_spike;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_spk_acc   <= '0;
            r_spike_vec <= '0;
            r_thr_q     <= '0;
            r_dbg_vmem  <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                r_v[n] <= '0;
                r_i[n] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= w_last;
            // Sampled before the edge: shows the membrane as of the previous edge.
            r_dbg_vmem <= r_v[dbg_sel];

            // A tick during RUN, including the final update cycle, is dropped.
            if (tick && (r_state == ST_RUN)) begin
                r_overrun <= 1'b1;
            end

            if (w_start) begin
                r_thr_q <= threshold;
                r_idx   <= '0;
            end

            if (r_state == ST_RUN) begin
                r_v[r_idx] <= w_v_out;
                r_spk_acc  <= w_acc_nxt;
                if (w_last) begin
                    r_spike_vec <= w_acc_nxt;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            // The update unit read r_i before this edge, so a write landing on
            // the neuron being updated right now takes effect next sweep.
            if (cfg_we) begin
                r_i[cfg_addr] <= cfg_data;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign spike_vec = r_spike_vec;
    assign dbg_vmem  = r_dbg_vmem;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_lif_ts_scheduler.sv
module tb_lif_ts_scheduler;

    localparam int N  = 8;
    localparam int VW = 16;
    localparam int IW = 8;
    localparam int LS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [VW-1:0] threshold = '0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [IW-1:0] cfg_data = '0;
    logic [2:0]    dbg_sel = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  spike_vec;
    logic [VW-1:0] dbg_vmem;
    logic          overrun;

    lif_ts_scheduler #(
        .N_NEURONS  (N),
        .V_WIDTH    (VW),
        .I_WIDTH    (IW),
        .LEAK_SHIFT (LS),
        .V_RESET    (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .threshold (threshold),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .dbg_sel   (dbg_sel),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec),
        .dbg_vmem  (dbg_vmem),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural reference: per-neuron state plus the position of the sweep
    // in progress (-1 when no sweep is running).
    int       m_v [N];
    int       m_i [N];
    int       m_thr;
    int       m_pos;
    logic [N-1:0] m_acc;
    logic [N-1:0] m_svec;
    bit       m_done;
    bit       m_over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_v[n] = 0;
            m_i[n] = 0;
        end
        m_thr  = 0;
        m_pos  = -1;
        m_acc  = '0;
        m_svec = '0;
        m_done = 0;
        m_over = 0;
    endtask

    // One clock with the given inputs; reference advanced, then all outputs compared.
    task automatic step(input bit tk, input bit we, input int addr, input int data,
                        input int thr, input int sel);
        int  exp_dbg;
        int  vs;
        bit  was_run;
        tick      = tk;
        cfg_we    = we;
        cfg_addr  = addr[2:0];
        cfg_data  = data[7:0];
        threshold = thr[15:0];
        dbg_sel   = sel[2:0];
        @(posedge clk);
        cyc++;
        exp_dbg = m_v[sel];
        m_done  = 0;
        was_run = (m_pos >= 0);
        if (was_run) begin
            vs = m_v[m_pos] - m_v[m_pos] / (1 << LS) + m_i[m_pos];
            if (vs > 65535) vs = 65535;
            if (vs >= m_thr) begin
                m_acc[m_pos] = 1'b1;
                m_v[m_pos]   = 0;
            end else begin
                m_acc[m_pos] = 1'b0;
                m_v[m_pos]   = vs;
            end
            if (m_pos == N - 1) begin
                m_svec = m_acc;
                m_done = 1;
                m_pos  = -1;
            end else begin
                m_pos++;
            end
        end
        if (tk) begin
            if (was_run) m_over = 1;
            else begin
                m_thr = thr;
                m_pos = 0;
            end
        end
        if (we) m_i[addr] = data;
        #1;
        chk("done", done, m_done);
        chk("busy", busy, m_pos >= 0);
        chk("overrun", overrun, m_over);
        chk("spike_vec", spike_vec, m_svec);
        chk("dbg_vmem", dbg_vmem, exp_dbg);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            tick     = c[0];
            cfg_we   = 1'b1;
            cfg_addr = c[2:0];
            cfg_data = 8'hAA;
            dbg_sel  = c[2:0];
            @(posedge clk);
            cyc++;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_spike_vec", spike_vec, 0);
            chk("rst_dbg_vmem", dbg_vmem, 0);
        end
        model_reset();
        rst_n  = 1'b1;
        tick   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic run_to_done(input int thr, output int n);
        n = 0;
        do begin
            step(0, 0, 0, 0, thr, $urandom_range(0, N - 1));
            n++;
        end while (!done && n < 20);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int lat;
    int dones;
    int last_done;
    int exp_sv0 [4] = '{0, 0, 1, 0};

    initial begin
        model_reset();
        do_reset(4);

        // Mid-sweep reset: build up some membrane state, then abort at idx 3.
        for (int n = 0; n < N; n++) step(0, 1, n, 20 + n, 1000, 0);
        step(1, 0, 0, 0, 1000, 0);
        run_to_done(1000, lat);
        step(1, 0, 0, 0, 1000, 0);
        while (m_pos != 3) step(0, 0, 0, 0, 1000, 0);
        do_reset(3);
        for (int n = 0; n < N; n++) step(0, 0, 0, 0, 0, n);

        // Single neuron integration: 40 -> 78 -> 114 (fires) -> 40.
        step(0, 1, 0, 40, 100, 0);
        for (int t = 0; t < 4; t++) begin
            step(1, 0, 0, 0, 100, 0);
            run_to_done(100, lat);
            chk("tick_to_done", lat, 8);
            chk("sv0", spike_vec[0], exp_sv0[t]);
        end
        step(0, 0, 0, 0, 100, 0);
        chk("v0_after4", dbg_vmem, 40);

        // Saturation / leak equilibrium, then a lower threshold fires everyone.
        do_reset(1);
        for (int n = 0; n < N; n++) step(0, 1, n, 255, 65535, 0);
        for (int t = 0; t < 150; t++) begin
            step(1, 0, 0, 0, 65535, 0);
            run_to_done(65535, lat);
        end
        for (int n = 0; n < N; n++) begin
            step(0, 0, 0, 0, 65535, n);
            chk("v_equilibrium", dbg_vmem, 4080);
        end
        step(1, 0, 0, 0, 4000, 0);
        run_to_done(4000, lat);
        chk("sat_spikes", spike_vec, 8'hFF);

        // Overrun: a second tick three cycles into the sweep.
        do_reset(1);
        for (int n = 0; n < N; n++) step(0, 1, n, $urandom_range(0, 255), 300, 0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step((c == 0) || (c == 3), 0, 0, 0, 300, 0);
            if (done) dones++;
        end
        chk("ovr_flag", overrun, 1);
        chk("ovr_dones", dones, 1);

        // Config write during a sweep: neuron 1 already updated, neuron 6 not yet.
        do_reset(1);
        step(1, 0, 0, 0, 30, 0);
        step(0, 0, 0, 0, 30, 0);
        step(0, 0, 0, 0, 30, 0);
        step(0, 1, 6, 50, 30, 0);
        step(0, 1, 1, 50, 30, 0);
        run_to_done(30, lat);
        chk("cfg_mid_sweep", spike_vec, 8'h40);

        // Back-to-back: tick in every done cycle.
        do_reset(1);
        for (int n = 0; n < N; n++) step(0, 1, n, $urandom_range(0, 255), 200, 0);
        last_done = -1;
        for (int s = 0; s < 5; s++) begin
            step(1, 0, 0, 0, 200, 0);
            run_to_done(200, lat);
            if (s > 0) chk("b2b_period", cyc - last_done, 9);
            last_done = cyc;
        end
        chk("b2b_overrun", overrun, 0);

        // Randomized traffic against the reference.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            int thr;
            case ($urandom_range(0, 9))
                0:       thr = 0;
                1:       thr = 65535;
                default: thr = $urandom_range(0, 600);
            endcase
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, N - 1), $urandom_range(0, 255), thr,
                 $urandom_range(0, N - 1));
            if (c == 1500) do_reset(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_ts_scheduler.md
# lif_ts_scheduler

Time-multiplexed scheduler that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` virtual neurons. It holds each neuron's membrane potential and input current in local registers. On every timestep `tick` it sweeps the neurons in index order, one per clock, and publishes the resulting spike vector with a one-cycle `done` pulse. It sits between the chip-level I/O wrapper, which drives ticks, configuration writes and debug selection, and the shared LIF update logic.

## Interface
- `N_NEURONS`, 8: number of virtual neurons; power of two, 2..32.
- `V_WIDTH`, 16: membrane potential width, unsigned.
- `I_WIDTH`, 8: input current width, unsigned.
- `LEAK_SHIFT`, 4: leak is `v >> LEAK_SHIFT`.
- `V_RESET`, 0: membrane value loaded after a spike.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `tick`, in, 1: starts one timestep sweep; single-cycle pulse.
- `threshold`, in, `V_WIDTH`: firing threshold, sampled on an accepted tick.
- `cfg_we`, in, 1: write enable for the input current register.
- `cfg_addr`, in, `$clog2(N_NEURONS)`: neuron index for the write.
- `cfg_data`, in, `I_WIDTH`: input current value to write.
- `dbg_sel`, in, `$clog2(N_NEURONS)`: neuron selected for debug readout.
- `busy`, out, 1: high while a sweep is in progress.
- `done`, out, 1: one-cycle pulse at the end of a sweep.
- `spike_vec`, out, `N_NEURONS`: spike results of the last completed sweep; bit i is neuron i.
- `dbg_vmem`, out, `V_WIDTH`: registered membrane potential of neuron `dbg_sel`.
- `overrun`, out, 1: sticky flag, set when a tick arrives while `busy`.

## Operation
FSM has two states, IDLE and RUN.

- **IDLE**
  - On `tick`: latch `threshold` into `thr_q`, set `idx=0`, go to RUN.
- **RUN**
  - Each cycle updates neuron `idx`: `v_sum = v[idx] - (v[idx] >> LEAK_SHIFT) + i[idx]`, computed in `V_WIDTH+1` bits.
  - The sum saturates at `2^V_WIDTH-1`.
  - If `v_sum >= thr_q`: `spk_acc[idx]=1` and `v[idx]=V_RESET`. Otherwise `spk_acc[idx]=0` and `v[idx]=v_sum`.
  - When `idx==N_NEURONS-1`: load `spike_vec` with the final accumulated vector, including this cycle's bit, pulse `done`, return to IDLE. Otherwise `idx++`.

Rules and boundary conditions:
- **Tick while busy:** the tick is ignored and `overrun` is set. `overrun` clears only on reset.
- **Tick in the same cycle as the last RUN update:** ignored and counts as an overrun.
- **`cfg_we` in any state:** writes `i[cfg_addr]` at the clock edge. During RUN, a neuron whose update edge coincides with the write uses the old value. A neuron updated later in the sweep uses the new value.
- **Threshold of 0:** every neuron spikes every timestep and its membrane stays at `V_RESET`.
- **Leak at small values:** the leak term is 0 whenever `v < 2^LEAK_SHIFT`. No underflow is possible.
- **`spike_vec`:** holds its value between sweeps and changes only on `done`.
- **Reset, including mid-sweep:** every `v` and `i` goes to 0, `spk_acc`, `spike_vec`, `thr_q`, `idx` and `dbg_vmem` go to 0, `busy`, `done` and `overrun` go to 0, and the FSM goes to IDLE. No `done` is emitted for an aborted sweep.

## Timing
- All outputs are registered, and all reset values are 0.
- Tick sampled at edge k:
  - `busy` is high from edge k.
  - Neuron j is updated at edge k+1+j.
  - At edge k+N_NEURONS: `done` goes high for one cycle, `spike_vec` becomes valid and `busy` drops.
- Tick-to-done latency is `N_NEURONS` cycles.
- Back-to-back: the earliest accepted next tick is at edge k+N_NEURONS+1, i.e. the tick asserted during the `done` cycle.
- `dbg_vmem` equals `v[dbg_sel]` as of the previous edge, so it has one cycle of latency.

## Structure
- Package `lif_pkg`: FSM state enum (`ST_IDLE`, `ST_RUN`), default width constants, and a saturating-add helper function.
- Sub-module `lif_update_unit`, purely combinational:
  - inputs: `v_in`, `i_in`, `thr`
  - outputs: `v_out`, `spike`
  - implements leak, add, saturate, compare and reset.
- The scheduler instantiates one `lif_update_unit` and owns the FSM, the register arrays and the outputs.

## Test plan
1. **Reset:** assert `rst_n=0` mid-sweep, at idx=3. Expect all outputs 0, `busy=0`, no `done`, and `dbg_vmem=0` for every `dbg_sel`.
2. **Single neuron integration:** `i[0]=40`, `thr=100`, defaults otherwise, 4 ticks.
   - v[0] sequence: 40 → 78 → 114 (spike).
   - Expected: spike_vec[0]=0, 0, 1, 0.
   - v[0] after tick 4 = 40.
   - `done` arrives exactly 8 cycles after each tick.
3. **Saturation:** `i=255`, `thr=0xFFFF`, run many ticks. Expect v to settle at the leak equilibrium of 4080 with no wrap. Then set `thr=4000` and expect a spike on the next tick.
4. **Overrun:** tick, then tick again 3 cycles later. Expect `overrun=1`, exactly one `done`, and v updated once.
5. **Config during sweep:** tick, then write `i[6]=50` and `i[1]=50` at update cycle 3 (all currents previously 0, `thr=30`). Expect spike_vec = 0x40: neuron 6 fires, neuron 1 does not.
6. **Back-to-back ticks:** a tick in every `done` cycle for 5 sweeps. Expect no overrun and a `done` period of 9 cycles.
